// File: rtl/reg_alu_16.sv
// 8x16 register file with two combinational read ports feeding a 2-bit-opcode ALU.
// Reads and ALU are zero-latency; writes land on the rising edge; there is no backpressure (one write per cycle).
module reg_alu_16 #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic              wr,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out_a,
  output logic [DATA_W-1:0] d_out_b,
  output logic              cout
);

  localparam int NREGS = 2 ** ADDR_W;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] wr_dat;
  logic [DATA_W:0]   sum_ext;

  assign d_out_a = regs[rd_addr_a];
  assign d_out_b = regs[rd_addr_b];

  // Subtraction is A + ~B + 1 so cout doubles as a "no borrow" flag.
  always_comb begin
    sum_ext = '0;
    alu_res = '0;
    cout    = 1'b0;
    case (op)
      OP_ADD: begin
        sum_ext = {1'b0, d_out_a} + {1'b0, d_out_b};
        alu_res = sum_ext[DATA_W-1:0];
        cout    = sum_ext[DATA_W];
      end
      OP_SUB: begin
        sum_ext = {1'b0, d_out_a} + {1'b0, ~d_out_b} + {{DATA_W{1'b0}}, 1'b1};
        alu_res = sum_ext[DATA_W-1:0];
        cout    = sum_ext[DATA_W];
      end
      OP_AND: alu_res = d_out_a & d_out_b;
      OP_OR:  alu_res = d_out_a | d_out_b;
      default: alu_res = '0;
    endcase
  end

  assign wr_dat = sel ? alu_res : d_in;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr) begin
      regs[wr_addr] <= wr_dat;
    end
  end

endmodule

// File: tb/tb_reg_alu_16.sv
// Bench for reg_alu_16: directed datapath sequence followed by random traffic against an array model.
module tb_reg_alu_16;

  logic        clk = 1'b0;
  logic        reset, sel, wr;
  logic [1:0]  op;
  logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic [15:0] d_in, d_out_a, d_out_b;
  logic        cout;

  int total = 0;
  int bad   = 0;
  logic [15:0] model [8];

  always #5 clk = ~clk;

  reg_alu_16 #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .sel(sel), .wr(wr), .op(op),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .wr_addr(wr_addr),
    .d_in(d_in), .d_out_a(d_out_a), .d_out_b(d_out_b), .cout(cout)
  );

  // Reference ALU in plain integer arithmetic: {carry/no-borrow, 16-bit result}.
  function automatic logic [16:0] alu_ref(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    int unsigned ai, bi, r;
    logic c;
    ai = a;
    bi = b;
    case (o)
      2'd0: begin r = ai + bi; c = (r > 32'd65535); end
      2'd1: begin r = (ai - bi) & 32'h0000_FFFF; c = (ai >= bi); end
      2'd2: begin r = ai & bi; c = 1'b0; end
      default: begin r = ai | bi; c = 1'b0; end
    endcase
    return {c, r[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [16:0] e;
    e = alu_ref(op, model[rd_addr_a], model[rd_addr_b]);
    chk({tag, "/a"}, {1'b0, d_out_a}, {1'b0, model[rd_addr_a]});
    chk({tag, "/b"}, {1'b0, d_out_b}, {1'b0, model[rd_addr_b]});
    chk({tag, "/cout"}, {16'd0, cout}, {16'd0, e[16]});
  endtask

  // Drive one cycle: check outputs before the edge, clock, update model, check again after.
  task automatic apply(input logic rst, input logic s, input logic w, input logic [1:0] o,
                       input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] wa,
                       input logic [15:0] d, input string tag);
    logic [16:0] e;
    reset = rst; sel = s; wr = w; op = o;
    rd_addr_a = ra; rd_addr_b = rb; wr_addr = wa; d_in = d;
    #1;
    check_outputs({tag, "/pre"});
    e = alu_ref(o, model[ra], model[rb]);
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    end else if (w) begin
      model[wa] = s ? e[15:0] : d;
    end
    #1;
    check_outputs({tag, "/post"});
  endtask

  task automatic dump_all(input string tag);
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 1'b0, 1'b0, 2'd0, 3'(i), 3'(7 - i), 3'd0, 16'h0000, tag);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    reset = 1'b0; sel = 1'b0; wr = 1'b1; op = 2'd0;
    rd_addr_a = 3'd0; rd_addr_b = 3'd0; wr_addr = 3'd0; d_in = 16'hFFFF;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i); rd_addr_b = 3'(i); reset = 1'b1; wr = 1'b0;
      #1;
      chk("reset_a", {1'b0, d_out_a}, 17'h0);
      chk("reset_cout", {16'd0, cout}, 17'h0);
    end

    // Loads; read port aimed at the write address to expose old/new values around the edge.
    apply(1'b1, 1'b0, 1'b1, 2'd0, 3'd3, 3'd3, 3'd3, 16'hCDEF, "load3");
    chk("load3_new", {1'b0, d_out_a}, {1'b0, 16'hCDEF});
    apply(1'b1, 1'b0, 1'b1, 2'd0, 3'd7, 3'd3, 3'd7, 16'h3210, "load7");
    chk("load7_new", {1'b0, d_out_a}, {1'b0, 16'h3210});
    apply(1'b1, 1'b0, 1'b1, 2'd0, 3'd5, 3'd7, 3'd5, 16'h4567, "load5");
    apply(1'b1, 1'b0, 1'b1, 2'd0, 3'd1, 3'd5, 3'd1, 16'hBA98, "load1");
    chk("load1_new", {1'b0, d_out_a}, {1'b0, 16'hBA98});

    apply(1'b1, 1'b0, 1'b0, 2'd0, 3'd5, 3'd1, 3'd3, 16'hxxxx, "hold");
    chk("hold_a", {1'b0, d_out_a}, {1'b0, 16'h4567});
    chk("hold_b", {1'b0, d_out_b}, {1'b0, 16'hBA98});
    dump_all("hold_dump");

    apply(1'b1, 1'b1, 1'b1, 2'd0, 3'd1, 3'd5, 3'd2, 16'h0000, "add");
    chk("add_cout", {16'd0, cout}, 17'h0);
    apply(1'b1, 1'b0, 1'b0, 2'd0, 3'd2, 3'd2, 3'd0, 16'h0000, "rd2");
    chk("add_res", {1'b0, d_out_a}, {1'b0, 16'hFFFF});

    apply(1'b1, 1'b1, 1'b1, 2'd1, 3'd3, 3'd7, 3'd4, 16'h0000, "sub");
    chk("sub_cout", {16'd0, cout}, 17'h1);
    apply(1'b1, 1'b1, 1'b1, 2'd1, 3'd7, 3'd3, 3'd6, 16'h0000, "subrev");
    chk("subrev_cout", {16'd0, cout}, 17'h0);
    apply(1'b1, 1'b0, 1'b0, 2'd0, 3'd4, 3'd6, 3'd0, 16'h0000, "rd46");
    chk("sub_res", {1'b0, d_out_a}, {1'b0, 16'h9BDF});
    chk("subrev_res", {1'b0, d_out_b}, {1'b0, 16'h6421});

    apply(1'b1, 1'b1, 1'b1, 2'd1, 3'd1, 3'd1, 3'd1, 16'h0000, "wb_src");
    chk("wb_src_res", {1'b0, d_out_a}, {1'b0, 16'h0000});

    apply(1'b1, 1'b1, 1'b1, 2'd2, 3'd3, 3'd7, 3'd0, 16'h1234, "and");
    chk("and_cout", {16'd0, cout}, 17'h0);
    apply(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0000, "rd0a");
    chk("and_res", {1'b0, d_out_a}, {1'b0, 16'h0000});
    apply(1'b1, 1'b1, 1'b1, 2'd3, 3'd3, 3'd7, 3'd0, 16'h1234, "or");
    chk("or_cout", {16'd0, cout}, 17'h0);
    apply(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0000, "rd0o");
    chk("or_res", {1'b0, d_out_a}, {1'b0, 16'hFFFF});

    apply(1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 3'd3, 3'd5, 16'hAAAA, "idle");
    dump_all("idle_dump");

    apply(1'b0, 1'b1, 1'b1, 2'd3, 3'd0, 3'd3, 3'd0, 16'h5555, "midrst");
    chk("midrst_a", {1'b0, d_out_a}, 17'h0);
    dump_all("midrst_dump");

    for (int n = 0; n < 400; n++) begin
      apply(($urandom_range(0, 31) != 0), 1'($urandom), 1'($urandom), 2'($urandom),
            3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom), "rand");
    end
    dump_all("final_dump");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
